udp_tx_noc_in: RTL
==================

// Module: udp_tx_noc_in
// PURPOSE
// - NoC receive stage at the UDP TX tile; consumes the messages built by the MRP TX NoC-out stage.
// - Reassembles each message into one UDP TX metadata beat plus a payload stream with last/padbytes.
// - Sits between the noc0 ctovr port and the UDP TX engine.
// - Message = NoC header flit, metadata flit, then N data flits.
// PARAMETERS
// - FLIT_BYTES  `NOC_DATA_WIDTH/8  payload bytes per data flit
// PORTS
// clk                                    in   1                    clock
// rst_n                                  in   1                    async reset, active low
// noc0_ctovr_udp_tx_in_val               in   1                    flit valid
// noc0_ctovr_udp_tx_in_data              in   `NOC_DATA_WIDTH      flit
// udp_tx_in_noc0_ctovr_rdy               out  1                    flit ready
// udp_tx_in_udp_engine_tx_meta_val       out  1                    metadata valid
// udp_tx_in_udp_engine_tx_src_ip         out  `IP_ADDR_W           source IP
// udp_tx_in_udp_engine_tx_dst_ip         out  `IP_ADDR_W           destination IP
// udp_tx_in_udp_engine_tx_src_port       out  `PORT_NUM_W          source port
// udp_tx_in_udp_engine_tx_dst_port       out  `PORT_NUM_W          destination port
// udp_tx_in_udp_engine_tx_len            out  `UDP_LENGTH_W        payload bytes
// udp_engine_udp_tx_in_tx_meta_rdy       in   1                    metadata ready
// udp_tx_in_udp_engine_tx_data_val       out  1                    payload valid
// udp_tx_in_udp_engine_tx_data           out  `MAC_INTERFACE_W     payload beat
// udp_tx_in_udp_engine_tx_data_last      out  1                    final beat
// udp_tx_in_udp_engine_tx_data_padbytes  out  `MAC_PADBYTES_W      invalid trailing bytes, last beat only
// udp_engine_udp_tx_in_tx_data_rdy       in   1                    payload ready
// udp_tx_in_len_err                      out  1                    one-cycle pulse, length mismatch
// BEHAVIOUR
// - One clock. Reset is asynchronous and active-low.
// - Reset: FSM=RX_HDR; all val outputs, last, and len_err are 0; registers are cleared.
// - Handshakes: a transfer occurs when val&rdy. Once raised, val and payload hold until accepted.
// - RX_HDR: rdy=1. On a flit, latch msg_len (flits after the header). Next state: RX_META.
// - RX_META: rdy=1. On a flit, latch ip/port/len.
//   - Set data_left = msg_len-1.
//   - Compute exp = ceil(len/FLIT_BYTES).
//   - If exp != data_left, pulse len_err the next cycle. The header count still governs framing.
//   - Next state: TX_META.
// - TX_META: meta_val=1, rdy=0.
//   - On meta accept: go to PASS_DATA if data_left!=0, else RX_HDR.
// - PASS_DATA: combinational cut-through.
//   - data_val = noc val; noc rdy = data_rdy; data = flit.
//   - last = (data_left==1).
//   - padbytes = last ? (FLIT_BYTES - len%FLIT_BYTES)%FLIT_BYTES : 0.
//   - Decrement data_left on each transfer. After the last transfer, go to RX_HDR.
// - Latency: meta_val rises 1 cycle after the metadata flit is accepted. Data adds 0 cycles.
// - Meta and data never overlap. The engine sees meta first for every message.
// - Back-to-back messages: a header flit is accepted in the cycle after the last data transfer.
// - len=0 with msg_len=1: meta only, no data beats.
// - msg_len=0 is illegal: pulse len_err, return to RX_HDR, emit no meta.
// - Reset mid-message: the partial message is dropped. After deassertion, the first flit is parsed as a header.
// STRUCTURE
// - Shared package udp_tx_noc_in_pkg:
//   - state enum {RX_HDR, RX_META, TX_META, PASS_DATA};
//   - meta-flit field offsets and packed struct;
//   - NoC header struct, shared with the MRP TX NoC-out stage.
// - Natural split: udp_tx_noc_in_ctrl (FSM, handshakes) and udp_tx_noc_in_datap (registers, data_left counter, padbytes, length check).
// TESTING
// - hdr msg_len=3, meta len=100, FLIT_BYTES=64, 2 data flits:
//   - meta out with len=100;
//   - beat0 last=0;
//   - beat1 last=1, padbytes=28.
// - len=128, msg_len=3: padbytes=0 on beat1; len_err never asserts.
// - meta_rdy=0 for 5 cycles: meta held stable; noc rdy=0 throughout; no data beats.
// - data_rdy toggling every other cycle: flit order preserved; no drop or duplication; data_left correct.
// - msg_len=1, len=0, immediately followed by a len=10 message:
//   - first message gives meta only;
//   - second message gives a single beat with last=1, padbytes=54.
// - msg_len=4 with len=64: len_err pulses once; 3 beats are forwarded with last on the third.
// - rst_n asserted during PASS_DATA: outputs go to 0 at once; the next message parses correctly.

Source files
------------

// File: rtl/udp_tx_noc_in_pkg.sv
// rtl/udp_tx_noc_in_pkg.sv - shared types, widths and field layout for the UDP TX NoC receive stage
// Flit layouts are shared with the MRP TX NoC-out stage that builds these messages.
package udp_tx_noc_in_pkg;

  localparam int unsigned NOC_DATA_WIDTH  = 512;
  localparam int unsigned FLIT_BYTES      = NOC_DATA_WIDTH / 8;
  localparam int unsigned IP_ADDR_W       = 32;
  localparam int unsigned PORT_NUM_W      = 16;
  localparam int unsigned UDP_LENGTH_W    = 16;
  localparam int unsigned MAC_INTERFACE_W = NOC_DATA_WIDTH;
  localparam int unsigned MAC_PADBYTES_W  = $clog2(FLIT_BYTES);
  localparam int unsigned MSG_LEN_W       = 8;

  typedef enum logic [1:0] {RX_HDR, RX_META, TX_META, PASS_DATA} state_e;

  // Bit offsets let the datapath slice fields without unused struct members.
  localparam int unsigned HDR_MSG_LEN_LSB   = 24;
  localparam int unsigned META_LEN_LSB      = 0;
  localparam int unsigned META_DST_PORT_LSB = 16;
  localparam int unsigned META_SRC_PORT_LSB = 32;
  localparam int unsigned META_DST_IP_LSB   = 48;
  localparam int unsigned META_SRC_IP_LSB   = 80;
  localparam int unsigned META_USED_W       = 112;

  typedef struct packed {
    logic [NOC_DATA_WIDTH-48-1:0] rsvd;
    logic [7:0]                   dst_x;
    logic [7:0]                   dst_y;
    logic [MSG_LEN_W-1:0]         msg_len;
    logic [7:0]                   msg_type;
    logic [7:0]                   src_x;
    logic [7:0]                   src_y;
  } noc_hdr_t;

  typedef struct packed {
    logic [NOC_DATA_WIDTH-META_USED_W-1:0] rsvd;
    logic [IP_ADDR_W-1:0]                  src_ip;
    logic [IP_ADDR_W-1:0]                  dst_ip;
    logic [PORT_NUM_W-1:0]                 src_port;
    logic [PORT_NUM_W-1:0]                 dst_port;
    logic [UDP_LENGTH_W-1:0]               len;
  } meta_flit_t;

  function automatic int unsigned flits_for_len(input logic [UDP_LENGTH_W-1:0] len);
    return (32'(len) + FLIT_BYTES - 1) / FLIT_BYTES;
  endfunction

  function automatic logic [MAC_PADBYTES_W-1:0] pad_for_len(input logic [UDP_LENGTH_W-1:0] len);
    int unsigned r;
    r = (FLIT_BYTES - (32'(len) % FLIT_BYTES)) % FLIT_BYTES;
    return r[MAC_PADBYTES_W-1:0];
  endfunction

endpackage

// File: rtl/udp_tx_noc_in_ctrl.sv
// rtl/udp_tx_noc_in_ctrl.sv - message FSM and NoC/engine handshakes
// Meta valid is registered; the data path is a combinational cut-through in PASS_DATA.
module udp_tx_noc_in_ctrl
  import udp_tx_noc_in_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic noc_val_i,
  input  logic meta_rdy_i,
  input  logic data_rdy_i,
  input  logic hdr_len_zero_i,
  input  logic data_left_zero_i,
  input  logic data_left_one_i,
  output logic noc_rdy_o,
  output logic hdr_fire_o,
  output logic meta_fire_o,
  output logic data_fire_o,
  output logic meta_val_o,
  output logic data_val_o,
  output logic data_last_o
);

  state_e state_q;
  logic   meta_val_q;

  always_comb begin
    noc_rdy_o   = 1'b0;
    data_val_o  = 1'b0;
    data_last_o = 1'b0;
    case (state_q)
      RX_HDR, RX_META: noc_rdy_o = 1'b1;
      PASS_DATA: begin
        noc_rdy_o   = data_rdy_i;
        data_val_o  = noc_val_i;
        data_last_o = data_left_one_i;
      end
      default: ;
    endcase
  end

  assign hdr_fire_o  = (state_q == RX_HDR)    && noc_val_i;
  assign meta_fire_o = (state_q == RX_META)   && noc_val_i;
  assign data_fire_o = (state_q == PASS_DATA) && noc_val_i && data_rdy_i;
  assign meta_val_o  = meta_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_HDR;
      meta_val_q <= 1'b0;
    end else begin
      case (state_q)
        RX_HDR: begin
          // A zero-length header carries no meta flit; stay here for the next header.
          if (hdr_fire_o && !hdr_len_zero_i) state_q <= RX_META;
        end
        RX_META: begin
          if (meta_fire_o) begin
            state_q    <= TX_META;
            meta_val_q <= 1'b1;
          end
        end
        TX_META: begin
          if (meta_rdy_i) begin
            meta_val_q <= 1'b0;
            state_q    <= data_left_zero_i ? RX_HDR : PASS_DATA;
          end
        end
        PASS_DATA: begin
          if (data_fire_o && data_left_one_i) state_q <= RX_HDR;
        end
        default: state_q <= RX_HDR;
      endcase
    end
  end

endmodule

// File: rtl/udp_tx_noc_in_datap.sv
// rtl/udp_tx_noc_in_datap.sv - field capture, flit countdown, padbytes and length check
// The header's flit count drives framing; the meta length only feeds padbytes and len_err.
module udp_tx_noc_in_datap
  import udp_tx_noc_in_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NOC_DATA_WIDTH-1:0]  flit_i,
  input  logic                       hdr_fire_i,
  input  logic                       meta_fire_i,
  input  logic                       data_fire_i,
  input  logic                       data_last_i,
  output logic                       hdr_len_zero_o,
  output logic                       data_left_zero_o,
  output logic                       data_left_one_o,
  output logic [IP_ADDR_W-1:0]       src_ip_o,
  output logic [IP_ADDR_W-1:0]       dst_ip_o,
  output logic [PORT_NUM_W-1:0]      src_port_o,
  output logic [PORT_NUM_W-1:0]      dst_port_o,
  output logic [UDP_LENGTH_W-1:0]    len_o,
  output logic [MAC_INTERFACE_W-1:0] data_o,
  output logic [MAC_PADBYTES_W-1:0]  padbytes_o,
  output logic                       len_err_o
);

  logic [MSG_LEN_W-1:0]    msg_len_q;
  logic [MSG_LEN_W-1:0]    data_left_q, data_left_d;
  logic [MSG_LEN_W-1:0]    data_left_init;
  logic [UDP_LENGTH_W-1:0] meta_len;
  logic                    len_err_q, len_err_d;
  logic                    len_mismatch;

  assign hdr_len_zero_o   = (flit_i[HDR_MSG_LEN_LSB +: MSG_LEN_W] == '0);
  assign meta_len         = flit_i[META_LEN_LSB +: UDP_LENGTH_W];
  assign data_left_init   = msg_len_q - MSG_LEN_W'(1);
  assign len_mismatch     = flits_for_len(meta_len) != 32'(data_left_init);
  assign data_left_zero_o = (data_left_q == '0);
  assign data_left_one_o  = (data_left_q == MSG_LEN_W'(1));
  assign data_o           = flit_i;
  assign padbytes_o       = data_last_i ? pad_for_len(len_o) : '0;
  assign len_err_o        = len_err_q;

  always_comb begin
    data_left_d = data_left_q;
    if (meta_fire_i)      data_left_d = data_left_init;
    else if (data_fire_i) data_left_d = data_left_q - MSG_LEN_W'(1);
    len_err_d = (hdr_fire_i && hdr_len_zero_o) || (meta_fire_i && len_mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len_q   <= '0;
      data_left_q <= '0;
      len_err_q   <= 1'b0;
      src_ip_o    <= '0;
      dst_ip_o    <= '0;
      src_port_o  <= '0;
      dst_port_o  <= '0;
      len_o       <= '0;
    end else begin
      data_left_q <= data_left_d;
      len_err_q   <= len_err_d;
      if (hdr_fire_i) msg_len_q <= flit_i[HDR_MSG_LEN_LSB +: MSG_LEN_W];
      if (meta_fire_i) begin
        src_ip_o   <= flit_i[META_SRC_IP_LSB   +: IP_ADDR_W];
        dst_ip_o   <= flit_i[META_DST_IP_LSB   +: IP_ADDR_W];
        src_port_o <= flit_i[META_SRC_PORT_LSB +: PORT_NUM_W];
        dst_port_o <= flit_i[META_DST_PORT_LSB +: PORT_NUM_W];
        len_o      <= meta_len;
      end
    end
  end

endmodule

// File: rtl/udp_tx_noc_in.sv
// rtl/udp_tx_noc_in.sv - NoC receive stage turning MRP messages into UDP TX meta + payload
// Message framing: header flit, metadata flit, then msg_len-1 data flits.
module udp_tx_noc_in
  import udp_tx_noc_in_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       noc0_ctovr_udp_tx_in_val,
  input  logic [NOC_DATA_WIDTH-1:0]  noc0_ctovr_udp_tx_in_data,
  output logic                       udp_tx_in_noc0_ctovr_rdy,
  output logic                       udp_tx_in_udp_engine_tx_meta_val,
  output logic [IP_ADDR_W-1:0]       udp_tx_in_udp_engine_tx_src_ip,
  output logic [IP_ADDR_W-1:0]       udp_tx_in_udp_engine_tx_dst_ip,
  output logic [PORT_NUM_W-1:0]      udp_tx_in_udp_engine_tx_src_port,
  output logic [PORT_NUM_W-1:0]      udp_tx_in_udp_engine_tx_dst_port,
  output logic [UDP_LENGTH_W-1:0]    udp_tx_in_udp_engine_tx_len,
  input  logic                       udp_engine_udp_tx_in_tx_meta_rdy,
  output logic                       udp_tx_in_udp_engine_tx_data_val,
  output logic [MAC_INTERFACE_W-1:0] udp_tx_in_udp_engine_tx_data,
  output logic                       udp_tx_in_udp_engine_tx_data_last,
  output logic [MAC_PADBYTES_W-1:0]  udp_tx_in_udp_engine_tx_data_padbytes,
  input  logic                       udp_engine_udp_tx_in_tx_data_rdy,
  output logic                       udp_tx_in_len_err
);

  logic hdr_fire, meta_fire, data_fire;
  logic hdr_len_zero, data_left_zero, data_left_one;

  udp_tx_noc_in_ctrl u_ctrl (
    .clk              (clk),
    .rst_n            (rst_n),
    .noc_val_i        (noc0_ctovr_udp_tx_in_val),
    .meta_rdy_i       (udp_engine_udp_tx_in_tx_meta_rdy),
    .data_rdy_i       (udp_engine_udp_tx_in_tx_data_rdy),
    .hdr_len_zero_i   (hdr_len_zero),
    .data_left_zero_i (data_left_zero),
    .data_left_one_i  (data_left_one),
    .noc_rdy_o        (udp_tx_in_noc0_ctovr_rdy),
    .hdr_fire_o       (hdr_fire),
    .meta_fire_o      (meta_fire),
    .data_fire_o      (data_fire),
    .meta_val_o       (udp_tx_in_udp_engine_tx_meta_val),
    .data_val_o       (udp_tx_in_udp_engine_tx_data_val),
    .data_last_o      (udp_tx_in_udp_engine_tx_data_last)
  );

  udp_tx_noc_in_datap u_datap (
    .clk              (clk),
    .rst_n            (rst_n),
    .flit_i           (noc0_ctovr_udp_tx_in_data),
    .hdr_fire_i       (hdr_fire),
    .meta_fire_i      (meta_fire),
    .data_fire_i      (data_fire),
    .data_last_i      (udp_tx_in_udp_engine_tx_data_last),
    .hdr_len_zero_o   (hdr_len_zero),
    .data_left_zero_o (data_left_zero),
    .data_left_one_o  (data_left_one),
    .src_ip_o         (udp_tx_in_udp_engine_tx_src_ip),
    .dst_ip_o         (udp_tx_in_udp_engine_tx_dst_ip),
    .src_port_o       (udp_tx_in_udp_engine_tx_src_port),
    .dst_port_o       (udp_tx_in_udp_engine_tx_dst_port),
    .len_o            (udp_tx_in_udp_engine_tx_len),
    .data_o           (udp_tx_in_udp_engine_tx_data),
    .padbytes_o       (udp_tx_in_udp_engine_tx_data_padbytes),
    .len_err_o        (udp_tx_in_len_err)
  );

endmodule
